// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bus bundle between the IF/MEM requesters, the byte-wide RAM
//               and the mem_arbiter. The slave modport is the arbiter side;
//               the master modport is the requester/RAM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              mem_req_i;
    logic              mem_we_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [2:0]        mem_len_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic [7:0]        ram_din_i;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [7:0]        ram_dout_o;
    logic              ram_wr_o;
    logic              if_done_o;
    logic [DATA_W-1:0] if_inst_o;
    logic              mem_done_o;
    logic [DATA_W-1:0] mem_rdata_o;
    logic              stall_if_o;
    logic              stall_mem_o;

    modport slave (
        input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i,
               mem_len_i, mem_wdata_i, ram_din_i,
        output ram_addr_o, ram_dout_o, ram_wr_o, if_done_o, if_inst_o,
               mem_done_o, mem_rdata_o, stall_if_o, stall_mem_o
    );

    modport master (
        output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i,
               mem_len_i, mem_wdata_i, ram_din_i,
        input  ram_addr_o, ram_dout_o, ram_wr_o, if_done_o, if_inst_o,
               mem_done_o, mem_rdata_o, stall_if_o, stall_mem_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Single-port byte-wide RAM controller shared by instruction
//               fetch (4-byte read) and MEM load/store (1/2/4 bytes).
//               Sequences transfers one byte per cycle, little-endian, and
//               raises stall requests until each transfer completes.
//               Optional macro MEM_ARB_FAIR_EN: alternate the winner on
//               simultaneous requests instead of strict MEM-over-IF.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_XFER = 2'd1;
    localparam logic [1:0] c_ST_FIN  = 2'd2;

    localparam logic c_OWN_IF  = 1'b0;
    localparam logic c_OWN_MEM = 1'b1;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_n;
    logic [2:0]        r_cnt;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_buf;
    logic              r_prev_fin;
    logic [DATA_W-1:0] r_if_inst;
    logic [DATA_W-1:0] r_mem_rdata;
`ifdef MEM_ARB_FAIR_EN
    logic              r_last_owner;
`endif

    logic              w_if_ok;
    logic              w_mem_ok;
    logic              w_grant;
    logic              w_grant_mem;
    logic [2:0]        w_mem_n;
    logic [1:0]        w_last_idx;
    logic [1:0]        w_cap_idx;
    logic [7:0]        w_wbyte;
    logic [DATA_W-1:0] w_assembled;
    logic              w_if_done;
    logic              w_mem_done;

    // A requester whose done pulsed last cycle may still be holding req high.
    assign w_if_ok  = bus.if_req_i  && !(r_prev_fin && (r_owner == c_OWN_IF));
    assign w_mem_ok = bus.mem_req_i && !(r_prev_fin && (r_owner == c_OWN_MEM));
    assign w_grant  = w_if_ok || w_mem_ok;

    assign w_last_idx = r_n[1:0] - 2'd1;
    assign w_cap_idx  = r_cnt[1:0] - 2'd1;

    // Pick the winner of a grant in IDLE.
    always_comb begin
        w_grant_mem = w_mem_ok;
        if (w_mem_ok && w_if_ok) begin
`ifdef MEM_ARB_FAIR_EN
            w_grant_mem = (r_last_owner == c_OWN_IF);
`else
            w_grant_mem = 1'b1;
`endif
        end
    end

    // Decode the MEM byte count; unsupported lengths become a full word.
    always_comb begin
        case (bus.mem_len_i)
            3'd1:    w_mem_n = 3'd1;
            3'd2:    w_mem_n = 3'd2;
            default: w_mem_n = 3'd4;
        endcase
    end

    // Select the store byte for the current beat.
    always_comb begin
        case (r_cnt[1:0])
            2'd0:    w_wbyte = r_wdata[7:0];
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            default: w_wbyte = r_wdata[31:24];
        endcase
    end

    // Final word: collected bytes with the last byte taken straight from RAM.
    always_comb begin
        w_assembled = r_buf;
        for (int k = 0; k < 4; k++) begin
            if (2'(k) == w_last_idx) begin
                w_assembled[8*k +: 8] = bus.ram_din_i;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (w_grant) w_next_state = c_ST_XFER;
            c_ST_XFER: if (r_cnt == (r_n - 3'd1)) w_next_state = c_ST_FIN;
            c_ST_FIN:  w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // Transfer controls, byte capture and held results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner     <= c_OWN_IF;
            r_we        <= 1'b0;
            r_base      <= '0;
            r_n         <= 3'd0;
            r_cnt       <= 3'd0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_prev_fin  <= 1'b0;
            r_if_inst   <= '0;
            r_mem_rdata <= '0;
`ifdef MEM_ARB_FAIR_EN
            r_last_owner <= c_OWN_IF;
`endif
        end else begin
            r_prev_fin <= (r_state == c_ST_FIN);
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_grant_mem;
                        r_we    <= w_grant_mem && bus.mem_we_i;
                        r_base  <= w_grant_mem ? bus.mem_addr_i : bus.if_addr_i;
                        r_n     <= w_grant_mem ? w_mem_n : 3'd4;
                        r_wdata <= bus.mem_wdata_i;
                        r_cnt   <= 3'd0;
                        r_buf   <= '0;
`ifdef MEM_ARB_FAIR_EN
                        r_last_owner <= w_grant_mem;
`endif
                    end
                end
                c_ST_XFER: begin
                    r_cnt <= r_cnt + 3'd1;
                    // Read data lags the address by one cycle.
                    if (!r_we && (r_cnt != 3'd0)) begin
                        for (int k = 0; k < 4; k++) begin
                            if (2'(k) == w_cap_idx) begin
                                r_buf[8*k +: 8] <= bus.ram_din_i;
                            end
                        end
                    end
                end
                c_ST_FIN: begin
                    if (r_owner == c_OWN_IF) begin
                        r_if_inst <= w_assembled;
                    end else if (!r_we) begin
                        r_mem_rdata <= w_assembled;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_if_done  = (r_state == c_ST_FIN) && (r_owner == c_OWN_IF);
    assign w_mem_done = (r_state == c_ST_FIN) && (r_owner == c_OWN_MEM);

    // RAM port, done pulses, result buses and stall requests.
    always_comb begin
        bus.ram_addr_o  = '0;
        bus.ram_dout_o  = 8'd0;
        bus.ram_wr_o    = 1'b0;
        bus.if_done_o   = w_if_done;
        bus.mem_done_o  = w_mem_done;
        bus.if_inst_o   = r_if_inst;
        bus.mem_rdata_o = r_mem_rdata;
        if (r_state == c_ST_XFER) begin
            bus.ram_addr_o = r_base + ADDR_W'(r_cnt);
            if (r_we) begin
                bus.ram_wr_o   = 1'b1;
                bus.ram_dout_o = w_wbyte;
            end
        end
        if (w_if_done) begin
            bus.if_inst_o = w_assembled;
        end
        if (w_mem_done && !r_we) begin
            bus.mem_rdata_o = w_assembled;
        end
        bus.stall_if_o  = bus.if_req_i  && !w_if_done;
        bus.stall_mem_o = bus.mem_req_i && !w_mem_done;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: byte RAM environment,
//               transaction-level reference model checked every cycle,
//               directed literal cases and randomized requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_AW    = 17;
    localparam int c_DEPTH = 1 << c_AW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(c_AW), .DATA_W(32)) bus ();
    mem_arbiter #(.ADDR_W(c_AW), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte RAM environment: synchronous read, write on strobe, preload port.
    logic [7:0]      ram [0:c_DEPTH-1];
    logic            ram_init = 1'b0;
    logic            pre_en   = 1'b0;
    logic [c_AW-1:0] pre_addr = '0;
    logic [7:0]      pre_data = 8'd0;

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int a = 0; a < c_DEPTH; a++) ram[a] <= 8'($urandom);
            ram_init <= 1'b1;
        end else begin
            if (pre_en) ram[pre_addr] <= pre_data;
            if (bus.ram_wr_o) ram[bus.ram_addr_o] <= bus.ram_dout_o;
        end
        bus.ram_din_i <= ram[bus.ram_addr_o];
    end

    // Reference model: a granted transfer occupies n beat cycles then one
    // done cycle; the cycle after done is idle and ignores that owner's req.
    logic            m_active = 1'b0, m_after_fin = 1'b0, m_owner_mem = 1'b0;
    logic            m_we = 1'b0, m_last_mem = 1'b0, pick_mem, ok_if, ok_mem;
    logic            e_if_done, e_mem_done;
    int              m_k = 0, m_n = 0;
    logic [c_AW-1:0] m_base = '0, a_beat;
    logic [31:0]     m_wdata = '0, m_data = '0, exp_inst = '0, exp_rdata = '0;

    function automatic int len_to_n(input logic [2:0] l);
        return (l == 3'd1) ? 1 : (l == 3'd2) ? 2 : 4;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_ram_wr",   {31'd0, bus.ram_wr_o},   32'd0);
            chk("rst_ram_addr", 32'(bus.ram_addr_o),     32'd0);
            chk("rst_ram_dout", 32'(bus.ram_dout_o),     32'd0);
            chk("rst_if_done",  {31'd0, bus.if_done_o},  32'd0);
            chk("rst_mem_done", {31'd0, bus.mem_done_o}, 32'd0);
            chk("rst_if_inst",  bus.if_inst_o,           32'd0);
            chk("rst_mem_rdata", bus.mem_rdata_o,        32'd0);
            m_active = 1'b0; m_after_fin = 1'b0; m_last_mem = 1'b0;
            exp_inst = '0; exp_rdata = '0;
        end else begin
            e_if_done = 1'b0; e_mem_done = 1'b0;
            if (m_active) begin
                if (m_k < m_n) begin
                    a_beat = m_base + c_AW'(m_k);
                    chk("beat_addr", 32'(bus.ram_addr_o), 32'(a_beat));
                    chk("beat_wr", {31'd0, bus.ram_wr_o}, {31'd0, m_we});
                    if (m_we) chk("beat_dout", 32'(bus.ram_dout_o), (m_wdata >> (8*m_k)) & 32'hFF);
                end else begin
                    chk("fin_wr", {31'd0, bus.ram_wr_o}, 32'd0);
                    if (m_owner_mem) begin
                        e_mem_done = 1'b1;
                        if (!m_we) exp_rdata = m_data;
                    end else begin
                        e_if_done = 1'b1;
                        exp_inst  = m_data;
                    end
                    m_active = 1'b0; m_after_fin = 1'b1;
                end
                m_k++;
            end else begin
                chk("idle_wr", {31'd0, bus.ram_wr_o}, 32'd0);
                ok_if  = bus.if_req_i  && !(m_after_fin && !m_owner_mem);
                ok_mem = bus.mem_req_i && !(m_after_fin &&  m_owner_mem);
                m_after_fin = 1'b0;
                if (ok_if || ok_mem) begin
                    pick_mem = ok_mem;
`ifdef MEM_ARB_FAIR_EN
                    if (ok_if && ok_mem) pick_mem = !m_last_mem;
`endif
                    m_owner_mem = pick_mem;
                    m_last_mem  = pick_mem;
                    m_we    = pick_mem && bus.mem_we_i;
                    m_base  = pick_mem ? bus.mem_addr_i : bus.if_addr_i;
                    m_n     = pick_mem ? len_to_n(bus.mem_len_i) : 4;
                    m_wdata = bus.mem_wdata_i;
                    m_data  = '0;
                    if (!m_we) begin
                        for (int i = 0; i < m_n; i++) begin
                            a_beat = m_base + c_AW'(i);
                            m_data = m_data | (32'(ram[a_beat]) << (8*i));
                        end
                    end
                    m_active = 1'b1; m_k = 0;
                end
            end
            chk("if_done",   {31'd0, bus.if_done_o},   {31'd0, e_if_done});
            chk("mem_done",  {31'd0, bus.mem_done_o},  {31'd0, e_mem_done});
            chk("if_inst",   bus.if_inst_o,   exp_inst);
            chk("mem_rdata", bus.mem_rdata_o, exp_rdata);
            chk("stall_if",  {31'd0, bus.stall_if_o},  {31'd0, bus.if_req_i && !e_if_done});
            chk("stall_mem", {31'd0, bus.stall_mem_o}, {31'd0, bus.mem_req_i && !e_mem_done});
        end
    end

    task automatic poke(input logic [c_AW-1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        pre_addr = a; pre_data = d; pre_en = 1'b1;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic do_if(input logic [c_AW-1:0] a, output logic [31:0] inst, output int lat);
        @(posedge clk); #1;
        bus.if_addr_i = a; bus.if_req_i = 1'b1;
        lat = 0; inst = '0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.if_done_o) begin lat = i; inst = bus.if_inst_o; break; end
        end
        if (lat == 0) chk("if_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.if_req_i = 1'b0;
    endtask

    task automatic do_mem(input logic we, input logic [c_AW-1:0] a, input logic [2:0] len,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        bus.mem_we_i = we; bus.mem_addr_i = a; bus.mem_len_i = len;
        bus.mem_wdata_i = wd; bus.mem_req_i = 1'b1;
        lat = 0; rd = '0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.mem_done_o) begin lat = i; rd = bus.mem_rdata_o; break; end
        end
        if (lat == 0) chk("mem_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.mem_req_i = 1'b0;
    endtask

    function automatic logic [c_AW-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return c_AW'(c_DEPTH - 1 - $urandom_range(0, 2));
        return c_AW'($urandom);
    endfunction

    task automatic rand_if_proc(input int cnt);
        logic [31:0] d; int l;
        for (int t = 0; t < cnt; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_if(rand_addr(), d, l);
        end
    endtask

    task automatic rand_mem_proc(input int cnt);
        logic [31:0] d; int l;
        for (int t = 0; t < cnt; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_mem(1'($urandom), rand_addr(), 3'($urandom), $urandom, d, l);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail + 1);
        $fatal(1);
    end

    initial begin : main
        logic [31:0] d1, d2;
        int l1, l2, seen, got;
        bus.if_req_i = 1'b0; bus.if_addr_i = '0;
        bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_addr_i = '0;
        bus.mem_len_i = 3'd0; bus.mem_wdata_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        poke(17'h00010, 8'h13); poke(17'h00011, 8'h05);
        poke(17'h00012, 8'h10); poke(17'h00013, 8'h00);
        do_if(17'h00010, d1, l1);
        chk("fetch_inst", d1, 32'h00100513);
        chk("fetch_lat", 32'(l1), 32'd6);

        do_mem(1'b1, 17'h00200, 3'd4, 32'hDEADBEEF, d1, l1);
        chk("store_lat", 32'(l1), 32'd6);
        @(negedge clk);
        chk("store_bytes", {ram[17'h203], ram[17'h202], ram[17'h201], ram[17'h200]}, 32'hDEADBEEF);

        poke(17'h00203, 8'h80);
        do_mem(1'b0, 17'h00203, 3'd1, 32'd0, d1, l1);
        chk("load1", d1, 32'h00000080);
        chk("load1_lat", 32'(l1), 32'd3);
        do_mem(1'b0, 17'h00202, 3'd2, 32'd0, d1, l1);
        chk("load2", d1, 32'h000080AD);

        poke(17'h1FFFF, 8'h34); poke(17'h00000, 8'h12);
        do_mem(1'b0, 17'h1FFFF, 3'd2, 32'd0, d1, l1);
        chk("wrap_load", d1, 32'h00001234);

        fork
            do_mem(1'b0, 17'h00203, 3'd1, 32'd0, d1, l1);
            do_if(17'h00010, d2, l2);
        join
        chk("simul_mem_data", d1, 32'h00000080);
        chk("simul_if_data", d2, 32'h00100513);
`ifdef MEM_ARB_FAIR_EN
        chk("simul_if_lat", 32'(l2), 32'd6);
        chk("simul_mem_lat", 32'(l1), 32'd9);
`else
        chk("simul_mem_lat", 32'(l1), 32'd3);
        chk("simul_if_lat", 32'(l2), 32'd9);
`endif

        // Requester drops req mid-fetch; the transfer still completes.
        @(posedge clk); #1;
        bus.if_addr_i = 17'h00040; bus.if_req_i = 1'b1;
        repeat (3) @(negedge clk);
        #1 bus.if_req_i = 1'b0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.if_done_o) begin got = 1; break; end
        end
        chk("drop_done", 32'(got), 32'd1);
        repeat (2) @(posedge clk);

        // Reset during the third store beat aborts the transfer.
        #1;
        bus.mem_we_i = 1'b1; bus.mem_addr_i = 17'h00300; bus.mem_len_i = 3'd4;
        bus.mem_wdata_i = 32'h11223344; bus.mem_req_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && seen < 2; i++) begin
            @(negedge clk);
            if (bus.ram_wr_o) seen++;
        end
        chk("abort_reached", 32'(seen), 32'd2);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_wr", {31'd0, bus.ram_wr_o}, 32'd0);
        chk("abort_done", {31'd0, bus.mem_done_o}, 32'd0);
        bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        do_if(17'h00010, d1, l1);
        chk("post_reset_fetch", d1, 32'h00100513);
        chk("post_reset_lat", 32'(l1), 32'd6);

        fork
            rand_if_proc(150);
            rand_mem_proc(150);
        join
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
